// File: rtl/coloring_search_ctrl_if.sv
// Host/checker-facing bus of the coloring search controller: request pulses,
// checker verdict in, candidate/result/status out.
interface coloring_search_ctrl_if #(
    parameter int CW = 22
);
    logic          start;
    logic          cont;
    logic          abort;
    logic          chk_ok;
    logic [CW-1:0] cand;
    logic          busy;
    logic          done;
    logic          found;
    logic [CW-1:0] result;
    logic [CW:0]   tries;

    modport master (
        output start, cont, abort, chk_ok,
        input  cand, busy, done, found, result, tries
    );

    modport slave (
        input  start, cont, abort, chk_ok,
        output cand, busy, done, found, result, tries
    );
endinterface

// File: rtl/coloring_search_ctrl.sv
// Sequential candidate enumerator for the graph-coloring checker: one candidate per cycle,
// captures the first accepted one. Define SYMBREAK_EN to pin vertex 0 to color 0.
module coloring_search_ctrl #(
    parameter int N_VERT  = 11,
    parameter int COLOR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coloring_search_ctrl_if.slave bus
);
    localparam int CW = N_VERT * COLOR_W;

`ifdef SYMBREAK_EN
    localparam logic [CW-1:0] STEP = CW'(1) << COLOR_W;
`else
    localparam logic [CW-1:0] STEP = CW'(1);
`endif
    localparam logic [CW-1:0] FIRST = '0;
    // Last candidate is the largest multiple of STEP below 2^CW.
    localparam logic [CW-1:0] LAST  = ~(STEP - CW'(1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cand;
    logic [CW-1:0] r_result;
    logic [CW:0]   r_tries;
    logic          r_found;

    logic [CW-1:0] w_cand_next;
    logic [CW-1:0] w_result_next;
    logic [CW:0]   w_tries_inc;

    assign w_cand_next   = r_cand + STEP;
    assign w_result_next = r_result + STEP;
    assign w_tries_inc   = r_tries + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cand   <= '0;
            r_result <= '0;
            r_tries  <= '0;
            r_found  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_cand  <= FIRST;
                        r_tries <= '0;
                        r_found <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (bus.chk_ok) begin
                        r_state  <= S_DONE;
                        r_result <= r_cand;
                        r_found  <= 1'b1;
                        r_tries  <= w_tries_inc;
                    end else if (r_cand == LAST) begin
                        r_state <= S_DONE;
                        r_found <= 1'b0;
                        r_tries <= w_tries_inc;
                    end else begin
                        r_cand  <= w_cand_next;
                        r_tries <= w_tries_inc;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_cand  <= FIRST;
                        r_tries <= '0;
                        r_found <= 1'b0;
                    end else if (bus.cont && r_found) begin
                        // Resuming past the last candidate has nothing left to try.
                        if (r_result == LAST) begin
                            r_found <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                            r_cand  <= w_result_next;
                            r_tries <= '0;
                            r_found <= 1'b0;
                        end
                    end else if (bus.abort) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cand   = r_cand;
    assign bus.result = r_result;
    assign bus.tries  = r_tries;
    assign bus.found  = r_found;
    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
endmodule

// File: doc/coloring_search_ctrl.md
# coloring_search_ctrl

Sequential search controller for the combinational graph-coloring checker. Enumerates candidate color assignments, drives them onto the checker's packed color input, samples its single-bit valid flag, and captures the first accepted assignment. Sits between a host/test harness and one checker instance. Supports restart, abort, and resume-from-last-solution to enumerate further colorings.

## Interface
- N_VERT, 11, number of graph vertices
- COLOR_W, 2, bits per vertex color; candidate width CW = N_VERT*COLOR_W
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin new search from candidate 0; honoured in IDLE or DONE
- cont  in  1  resume search after last result; honoured in DONE with found=1
- abort  in  1  terminate running search, return to IDLE
- chk_ok  in  1  checker verdict for current cand, combinational from cand
- cand  out  CW  registered candidate driven to checker; vertex v color = cand[v*COLOR_W +: COLOR_W]
- busy  out  1  high in RUN
- done  out  1  high in DONE, held until next start/cont
- found  out  1  valid only with done: 1 = result holds accepted coloring, 0 = space exhausted
- result  out  CW  last accepted candidate
- tries  out  CW+1  candidates evaluated in current search, including accepted one

## Operation
- States IDLE, RUN, DONE. Reset: IDLE; cand, result, tries = 0; busy, done, found = 0.
- IDLE: start -> RUN, cand<=FIRST, tries<=0, found<=0.
- RUN, each edge, priority order:
  - abort -> IDLE; cand, tries hold; result/found unchanged; no done.
  - chk_ok=1 -> DONE, result<=cand, found<=1, tries<=tries+1.
  - cand==LAST -> DONE, found<=0, tries<=tries+1; result unchanged.
  - else cand<=cand+STEP, tries<=tries+1.
- start/cont during RUN ignored.
- DONE: start -> as from IDLE (tries cleared). cont with found=1 and result!=LAST -> RUN, cand<=result+STEP, tries<=0, found<=0. cont with found=1 and result==LAST -> stay DONE, found<=0. cont with found=0 ignored. start and cont together: start wins. abort in DONE -> IDLE.
- Default: FIRST=0, STEP=1, LAST=2^CW-1. Arithmetic unsigned, CW bits; no wrap reachable since LAST terminates.
- tries is CW+1 bits so exhaustive count 2^CW fits without overflow.

## Timing
- start sampled at edge 0 -> busy=1, cand=FIRST after edge 0.
- Candidate k-th in order (k from 0) evaluated at edge k+1; done=1 visible after that edge.
- One candidate per cycle; chk_ok must settle within one cycle of cand changing.
- busy and done never both high; done falls the edge after accepted start/cont/abort.
- Async reset mid-RUN: immediate return to reset values; no done.

## Configuration
- SYMBREAK_EN defined: vertex 0 color pinned to 0; cand[COLOR_W-1:0] always 0; FIRST=0, STEP=2^COLOR_W, LAST=2^CW-2^COLOR_W; search space reduced by 2^COLOR_W; cont computes result+STEP.
- SYMBREAK_EN undefined: full enumeration per Operation defaults.

## Test plan
- Stub chk_ok=(cand==37), start pulse -> done after 38 edges, found=1, result=37, tries=38, busy low thereafter.
- Stub chk_ok=0, N_VERT=3, COLOR_W=2 -> done after 64 edges, found=0, tries=64, result=0.
- Stub chk_ok=(cand==5||cand==9), start then cont in DONE -> first result=5 tries=6; after cont result=9 tries=4.
- Stub chk_ok=(cand==37), abort at edge 10 -> IDLE, busy=0, done=0, cand=9; abort with chk_ok=1 same edge -> IDLE, result unchanged.
- Real myciel3 checker, start -> found=1; independently recheck result has no equal-colored adjacent pair; with SYMBREAK_EN, result[1:0]=0 and tries<=1048576.
- Assert rst_n low mid-RUN at cand=20 -> all outputs 0 immediately; subsequent start searches from 0.
